// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: two-requester round-robin sequencer for a combinational 256x8 memory.
// Commands run IDLE -> ACCESS -> DONE; all memory-side signals come straight from registers.
`default_nettype none

module mem_rr_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [DATA_W-1:0] mem_write_in,
  input  logic [DATA_W-1:0] mem_read_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              cmd_we;
  logic              cmd_id;
  logic              last_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;
  logic              win_id;

  // On a tie the requester not served last wins; otherwise the sole requester.
  assign any_req = |req_i;
  assign win_id  = (req_i == 2'b11) ? ~last_id : req_i[1];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    gnt_o        = 2'b00;
    done_o       = 2'b00;
    busy_o       = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        busy_o        = 1'b1;
        gnt_o[cmd_id] = 1'b1;
        mem_write_en  = cmd_we;
        mem_read_en   = ~cmd_we;
        state_nxt     = DONE;
      end
      DONE: begin
        busy_o         = 1'b1;
        done_o[cmd_id] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured command stays frozen from arbitration until the next IDLE, so
  // address and write data are stable for the whole strobe cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_we    <= 1'b0;
      cmd_id    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
      last_id   <= 1'b1;
    end else begin
      if (state == IDLE && any_req) begin
        cmd_id    <= win_id;
        cmd_we    <= we_i[win_id];
        cmd_addr  <= win_id ? addr1_i : addr0_i;
        cmd_wdata <= win_id ? wdata1_i : wdata0_i;
      end
      if (state == ACCESS && !cmd_we) rdata_q <= mem_read_out;
      if (state == DONE) last_id <= cmd_id;
    end
  end

  assign mem_addr     = cmd_addr;
  assign mem_write_in = cmd_wdata;
  assign rdata_o      = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed self-checking bench with a behavioural 256x8 memory.
`default_nettype none

module tb_mem_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] we = 2'b00;
  logic [7:0] addr0 = 8'h00;
  logic [7:0] addr1 = 8'h00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] rdata;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_write_en;
  logic       mem_read_en;
  logic [7:0] mem_write_in;
  logic [7:0] mem_read_out;

  logic [7:0] mem [256];
  logic       mem_clr = 1'b1;
  logic       excl_on = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  mem_rr_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .busy_o(busy),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_write_in(mem_write_in), .mem_read_out(mem_read_out)
  );

  always #5 clk = ~clk;

  // Memory preloads with addr ^ 0x5A so reads of unwritten words are predictable.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (mem_write_en) begin
      mem[mem_addr] <= mem_write_in;
    end
  end
  assign mem_read_out = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (excl_on) check("strobe_excl", 32'({mem_write_en, mem_read_en} == 2'b11), 32'd0);
  end

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_wen"}, 32'(mem_write_en), 32'd0);
    check({tag, "_ren"}, 32'(mem_read_en), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_win"}, 32'(mem_write_in), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Caller sits at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_cmd(input int id, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] rexp, input string tag);
    if (id == 0) begin addr0 = a; wdata0 = d; end
    else         begin addr1 = a; wdata1 = d; end
    we[id]  = w;
    req[id] = 1'b1;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(gnt), 32'(2'b01 << id));
    check({tag, "_wen"}, 32'(mem_write_en), 32'(w));
    check({tag, "_ren"}, 32'(mem_read_en), 32'(!w));
    check({tag, "_addr"}, 32'(mem_addr), 32'(a));
    if (w) check({tag, "_wdata"}, 32'(mem_write_in), 32'(d));
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(2'b01 << id));
    check({tag, "_strobes_off"}, 32'({mem_write_en, mem_read_en}), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'(rexp));
    req[id] = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    logic [1:0] seq [4];
    int         ng;
    int         nd;

    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    check_quiet("rst0");

    // Reset asserted in the middle of a write: command dropped, no done.
    addr0 = 8'h55; wdata0 = 8'h11; we = 2'b01; req = 2'b01;
    @(negedge clk);
    check("rstmid_gnt_before", 32'(gnt), 32'd1);
    rst_n = 1'b0; req = 2'b00;
    @(negedge clk);
    check_quiet("rstmid1");
    @(negedge clk);
    check_quiet("rstmid2");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("rstmid3");

    // Tie right after reset: requester 0 first, then 1.
    addr0 = 8'h10; addr1 = 8'h20; we = 2'b00; req = 2'b11;
    @(negedge clk);
    check("tie_gnt0", 32'(gnt), 32'd1);
    check("tie_addr0", 32'(mem_addr), 32'h10);
    @(negedge clk);
    check("tie_done0", 32'(done), 32'd1);
    check("tie_rdata0", 32'(rdata), 32'h4A);
    req = 2'b10;
    @(negedge clk);
    check("tie_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("tie_gnt1", 32'(gnt), 32'd2);
    check("tie_addr1", 32'(mem_addr), 32'h20);
    @(negedge clk);
    check("tie_done1", 32'(done), 32'd2);
    check("tie_rdata1", 32'(rdata), 32'h7A);
    req = 2'b00;
    @(negedge clk);

    // Single write then read back through the other requester.
    run_cmd(0, 1'b1, 8'h3C, 8'hA5, 8'h7A, "wr3c");
    run_cmd(1, 1'b0, 8'h3C, 8'h00, 8'hA5, "rd3c");

    // Boundary addresses and data; strobe exclusivity watched every cycle.
    excl_on = 1'b1;
    run_cmd(0, 1'b1, 8'hFF, 8'hFF, 8'hA5, "wrff");
    run_cmd(1, 1'b1, 8'h00, 8'h00, 8'hA5, "wr00");
    run_cmd(0, 1'b0, 8'hFF, 8'h00, 8'hFF, "rdff");
    run_cmd(1, 1'b0, 8'h00, 8'h00, 8'h00, "rd00");

    // r0 drops its request in ACCESS and changes its address; command still completes.
    addr0 = 8'h3C; we = 2'b00; req = 2'b01;
    @(negedge clk);
    check("drop_gnt0", 32'(gnt), 32'd1);
    req = 2'b10; addr0 = 8'h00; addr1 = 8'hFF;
    @(negedge clk);
    check("drop_done0", 32'(done), 32'd1);
    check("drop_rdata0", 32'(rdata), 32'hA5);
    @(negedge clk);
    check("drop_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("drop_gnt1", 32'(gnt), 32'd2);
    check("drop_addr1", 32'(mem_addr), 32'hFF);
    @(negedge clk);
    check("drop_done1", 32'(done), 32'd2);
    check("drop_rdata1", 32'(rdata), 32'hFF);
    req = 2'b00;
    @(negedge clk);
    excl_on = 1'b0;

    // Fairness: both requesting for 12 cycles after a fresh reset.
    do_reset();
    @(negedge clk);
    ng = 0; nd = 0;
    for (int k = 0; k < 4; k++) seq[k] = 2'b00;
    we = 2'b00; req = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        if (ng < 4) seq[ng] = gnt;
        ng++;
      end
      if (done != 2'b00) nd++;
    end
    req = 2'b00;
    check("fair_ngrant", 32'(ng), 32'd4);
    check("fair_ndone", 32'(nd), 32'd4);
    check("fair_g0", 32'(seq[0]), 32'd1);
    check("fair_g1", 32'(seq[1]), 32'd2);
    check("fair_g2", 32'(seq[2]), 32'd1);
    check("fair_g3", 32'(seq[3]), 32'd2);
    repeat (3) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
